// File: rtl/media_blocos.sv
// Block-average image downscaler: reads a source frame from a synchronous ROM
// and writes the mean of each FATORxFATOR block to RAM. `MEDIA_BLOCOS_ROUND_EN` selects round-half-up.
module media_blocos #(
  parameter int FATOR   = 2,
  parameter int LARGURA = 160,
  parameter int ALTURA  = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [18:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        ram_we,
  output logic [18:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        busy,
  output logic        done
);

  localparam int LG = (FATOR == 4) ? 2 : 1;
  localparam int SH = 2 * LG;
  localparam int AW = 8 + SH;
  localparam int OW = LARGURA / FATOR;
  localparam int OH = ALTURA / FATOR;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH,
    FIM
  } st_t;

  st_t st;

  logic [1:0]    dj, di;
  logic [9:0]    oc, ol;
  logic [18:0]   linha, coluna, addr;
  logic          last_dj, last_di, last_oc, last_ol;
  logic          v0, v1, first0, first1, last0, last1;
  logic [AW-1:0] acc, base, sum, rsum;
  logic [7:0]    res;
  logic [18:0]   wcnt;
  logic [1:0]    fcnt;

  assign linha   = 19'(ol) * 19'(FATOR) + 19'(di);
  assign coluna  = 19'(oc) * 19'(FATOR) + 19'(dj);
  assign addr    = linha * 19'(LARGURA) + coluna;
  assign last_dj = (dj == 2'(FATOR - 1));
  assign last_di = (di == 2'(FATOR - 1));
  assign last_oc = (oc == 10'(OW - 1));
  assign last_ol = (ol == 10'(OH - 1));

  // Running block sum; the first sample of a block replaces the old total
  always_comb begin
    base = first1 ? '0 : acc;
    sum  = base + AW'(rom_data);
`ifdef MEDIA_BLOCOS_ROUND_EN
    rsum = sum + AW'(FATOR * FATOR / 2);
`else
    rsum = sum;
`endif
    res  = 8'(rsum >> SH);
  end

  // Control FSM, address scan, sample pipeline and write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      dj       <= '0;
      di       <= '0;
      oc       <= '0;
      ol       <= '0;
      v0       <= 1'b0;
      v1       <= 1'b0;
      first0   <= 1'b0;
      first1   <= 1'b0;
      last0    <= 1'b0;
      last1    <= 1'b0;
      acc      <= '0;
      wcnt     <= '0;
      fcnt     <= '0;
      rom_addr <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      done   <= 1'b0;
      v0     <= 1'b0;
      v1     <= v0;
      first1 <= first0;
      last1  <= last0;
      if (v1)
        acc <= sum;
      if (v1 && last1) begin
        ram_we   <= 1'b1;
        ram_data <= res;
        ram_addr <= wcnt;
        wcnt     <= wcnt + 19'd1;
      end
      unique case (st)
        IDLE: begin
          if (start) begin
            st   <= READ;
            wcnt <= '0;
          end
        end
        READ: begin
          busy     <= 1'b1;
          rom_addr <= addr;
          v0       <= 1'b1;
          first0   <= (dj == 2'd0) && (di == 2'd0);
          last0    <= last_dj && last_di;
          dj       <= dj + 2'd1;
          if (last_dj) begin
            dj <= '0;
            di <= di + 2'd1;
            if (last_di) begin
              di <= '0;
              oc <= oc + 10'd1;
              if (last_oc) begin
                oc <= '0;
                ol <= ol + 10'd1;
                if (last_ol) begin
                  ol   <= '0;
                  st   <= FLUSH;
                  fcnt <= '0;
                end
              end
            end
          end
        end
        FLUSH: begin
          fcnt <= fcnt + 2'd1;
          if (fcnt == 2'd2) begin
            st   <= FIM;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        FIM: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule
